// File: rtl/iob2axi_ctrl_pkg.sv
// Shared types and constants for the iob2axi transfer sequencer.
// Build option: define IOB2AXI_CTRL_4K_EN to keep every burst inside one 4 KiB page.
package iob2axi_ctrl_pkg;

    localparam int AXI_LEN_W = 8;
    localparam int BEATS_W   = 9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        ST_WAIT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    function automatic int log2_bpb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/iob2axi_ctrl_if.sv
// Descriptor and iob2axi control signals of the sequencer, bundled with master/slave views.
// Build option: none here; IOB2AXI_CTRL_4K_EN only changes burst sizing inside the slave.
interface iob2axi_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    import iob2axi_ctrl_pkg::*;

    // Handshakes: a descriptor is taken when start=1 and busy=0 (start is the valid, !busy
    // the ready); a burst is launched by a one-cycle run pulse issued only while xfer_ready=1,
    // and completes on the next xfer_ready=1 seen after the cycle following run.
    logic                 start;
    logic                 dir;
    logic [ADDR_W-1:0]    addr;
    logic [CNT_W-1:0]     nbeats;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic                 run;
    logic                 direction;
    logic [AXI_LEN_W-1:0] length;
    logic                 xfer_ready;
    logic                 xfer_error;
    logic [ADDR_W-1:0]    burst_addr;
    logic                 burst_valid;

    modport master (
        output start, dir, addr, nbeats, xfer_ready, xfer_error,
        input  busy, done, error, run, direction, length, burst_addr, burst_valid
    );

    modport slave (
        input  start, dir, addr, nbeats, xfer_ready, xfer_error,
        output busy, done, error, run, direction, length, burst_addr, burst_valid
    );

endinterface

// File: rtl/iob2axi_burst_calc.sv
// Combinational size of the next burst: min of remaining beats, MAX_BURST and (optionally)
// the distance to the next 4 KiB page. Build option: IOB2AXI_CTRL_4K_EN adds the page term.
module iob2axi_burst_calc
    import iob2axi_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 256
) (
    input  logic [CNT_W-1:0]   remaining,
    input  logic [11:0]        addr_lo,
    output logic [BEATS_W-1:0] beats
);

    localparam int LOG2_BPB = log2_bpb(DATA_W);

    logic [31:0] cap;

`ifdef IOB2AXI_CTRL_4K_EN
    logic [12:0] bytes_to_4k;
    logic [31:0] beats_to_4k;
`else
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr_lo;
`endif

    always_comb begin
        cap = 32'(MAX_BURST);
`ifdef IOB2AXI_CTRL_4K_EN
        bytes_to_4k = 13'h1000 - {1'b0, addr_lo};
        beats_to_4k = 32'(bytes_to_4k >> LOG2_BPB);
        if (beats_to_4k < cap) cap = beats_to_4k;
`endif
        if (32'(remaining) < cap) cap = 32'(remaining);
        beats = BEATS_W'(cap);
    end

endmodule

// File: rtl/iob2axi_ctrl.sv
// Transfer sequencer: splits one descriptor into AXI4 bursts and drives iob2axi run/length.
// Build option: IOB2AXI_CTRL_4K_EN (via iob2axi_burst_calc) forbids 4 KiB page crossings.
module iob2axi_ctrl
    import iob2axi_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_BURST = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    iob2axi_ctrl_if.slave   ifc,
    output state_t          dbg_state
);

    localparam int BPB      = DATA_W / 8;
    localparam int LOG2_BPB = log2_bpb(DATA_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BPB - 1);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ADDR_W-1:0]    burst_addr_q, burst_addr_d;
    logic [CNT_W-1:0]     remaining_q, remaining_d, remaining_next;
    logic [BEATS_W-1:0]   beats_q, beats_d, beats_calc;
    logic [AXI_LEN_W-1:0] length_q, length_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 run_q, run_d;
    logic                 direction_q, direction_d;
    logic                 burst_valid_q, burst_valid_d;

    iob2axi_burst_calc #(
        .CNT_W     (CNT_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .remaining (remaining_q),
        .addr_lo   (addr_q[11:0]),
        .beats     (beats_calc)
    );

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        burst_addr_d   = burst_addr_q;
        remaining_d    = remaining_q;
        beats_d        = beats_q;
        length_d       = length_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        error_d        = error_q;
        run_d          = 1'b0;
        direction_d    = direction_q;
        burst_valid_d  = burst_valid_q;
        remaining_next = remaining_q - CNT_W'(beats_q);

        case (state_q)
            ST_IDLE: begin
                if (ifc.start) begin
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    direction_d = ifc.dir;
                    addr_d      = ifc.addr & ALIGN_MASK;
                    remaining_d = ifc.nbeats;
                    state_d     = (ifc.nbeats == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                beats_d       = beats_calc;
                length_d      = AXI_LEN_W'(beats_calc - BEATS_W'(1));
                burst_addr_d  = addr_q;
                burst_valid_d = 1'b1;
                state_d       = ST_RUN;
            end
            ST_RUN: begin
                if (ifc.xfer_ready) begin
                    run_d   = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            // iob2axi still shows the stale ready here; it drops one cycle after run.
            ST_HOLD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (ifc.xfer_ready) begin
                    addr_d        = addr_q + (ADDR_W'(beats_q) << LOG2_BPB);
                    remaining_d   = remaining_next;
                    burst_valid_d = 1'b0;
                    if (ifc.xfer_error) begin
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (remaining_next == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            burst_addr_q  <= '0;
            remaining_q   <= '0;
            beats_q       <= '0;
            length_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            run_q         <= 1'b0;
            direction_q   <= 1'b0;
            burst_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            burst_addr_q  <= burst_addr_d;
            remaining_q   <= remaining_d;
            beats_q       <= beats_d;
            length_q      <= length_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            run_q         <= run_d;
            direction_q   <= direction_d;
            burst_valid_q <= burst_valid_d;
        end
    end

    assign ifc.busy        = busy_q;
    assign ifc.done        = done_q;
    assign ifc.error       = error_q;
    assign ifc.run         = run_q;
    assign ifc.direction   = direction_q;
    assign ifc.length      = length_q;
    assign ifc.burst_addr  = burst_addr_q;
    assign ifc.burst_valid = burst_valid_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_iob2axi_ctrl.sv
// Randomized bench for iob2axi_ctrl: a page/size splitting model predicts every burst,
// a responder plays iob2axi. Follows IOB2AXI_CTRL_4K_EN the same way the design does.
module tb_iob2axi_ctrl;
    import iob2axi_ctrl_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 16;
    localparam int MAX_BURST = 256;
    localparam int BPB       = DATA_W / 8;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;

    iob2axi_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) ifc ();

    iob2axi_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ifc       (ifc),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0]    exp_addr_q[$];
    logic [AXI_LEN_W-1:0] exp_len_q[$];
    logic                 exp_dir = 1'b0;
    logic                 exp_err = 1'b0;
    int                   resp_err_idx = -1;
    int                   resp_cnt = 0;
    logic [ADDR_W-1:0]    mon_addr;
    logic [AXI_LEN_W-1:0] mon_len;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected bursts from the splitting rules, stopping after the burst that reports an error.
    task automatic model_xfer(input logic [ADDR_W-1:0] a_in, input int n, input int err_idx);
        logic [ADDR_W-1:0] a;
        int rem, b, idx;
`ifdef IOB2AXI_CTRL_4K_EN
        int to_page;
`endif
        a = a_in & ~ADDR_W'(BPB - 1);
        rem = n;
        idx = 0;
        exp_err = 1'b0;
        while (rem > 0) begin
            b = (rem < MAX_BURST) ? rem : MAX_BURST;
`ifdef IOB2AXI_CTRL_4K_EN
            to_page = (4096 - int'(a[11:0])) / BPB;
            if (to_page < b) b = to_page;
`endif
            exp_addr_q.push_back(a);
            exp_len_q.push_back(AXI_LEN_W'(b - 1));
            a = a + ADDR_W'(b * BPB);
            rem = rem - b;
            if (idx == err_idx) begin
                exp_err = 1'b1;
                break;
            end
            idx++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ifc.run) begin
            if (exp_len_q.size() == 0) begin
                check("unexpected_run", 1, 0);
            end else begin
                mon_addr = exp_addr_q.pop_front();
                mon_len  = exp_len_q.pop_front();
                check("burst_addr", ifc.burst_addr, mon_addr);
                check("length", ifc.length, mon_len);
                check("direction", ifc.direction, exp_dir);
                check("burst_valid", ifc.burst_valid, 1);
            end
        end
    end

    // iob2axi stand-in: drops ready the cycle after run, raises it again 1..4 cycles later.
    initial begin
        ifc.xfer_ready = 1'b1;
        ifc.xfer_error = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && ifc.run) begin
                resp_cnt++;
                @(posedge clk);
                #1;
                ifc.xfer_ready = 1'b0;
                ifc.xfer_error = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                ifc.xfer_ready = 1'b1;
                ifc.xfer_error = ((resp_cnt - 1) == resp_err_idx);
            end
        end
    end

    task automatic start_xfer(input logic [ADDR_W-1:0] a, input int n, input logic d,
                              input int err_idx);
        exp_dir      = d;
        resp_err_idx = err_idx;
        resp_cnt     = 0;
        model_xfer(a, n, err_idx);
        @(negedge clk);
        ifc.start  = 1'b1;
        ifc.dir    = d;
        ifc.addr   = a;
        ifc.nbeats = CNT_W'(n);
        @(negedge clk);
        ifc.start  = 1'b0;
        ifc.dir    = ~d;
        ifc.addr   = $urandom;
        ifc.nbeats = CNT_W'($urandom);
        check("busy_on_accept", ifc.busy, 1);
        check("error_cleared", ifc.error, 0);
    endtask

    task automatic wait_done(input int budget);
        int cyc;
        cyc = 0;
        while (!ifc.done && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", ifc.done, 1);
        check("busy_at_done", ifc.busy, 0);
        check("error_flag", ifc.error, exp_err);
        check("bursts_left", exp_len_q.size(), 0);
        exp_addr_q.delete();
        exp_len_q.delete();
        @(negedge clk);
        check("done_one_cycle", ifc.done, 0);
        check("error_sticky", ifc.error, exp_err);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, ifc.busy, 0);
        check({tag, "_done"}, ifc.done, 0);
        check({tag, "_error"}, ifc.error, 0);
        check({tag, "_run"}, ifc.run, 0);
        check({tag, "_dir"}, ifc.direction, 0);
        check({tag, "_len"}, ifc.length, 0);
        check({tag, "_baddr"}, ifc.burst_addr, 0);
        check({tag, "_bvalid"}, ifc.burst_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] ra;
        int rn, re, cyc;

        ifc.start  = 1'b0;
        ifc.dir    = 1'b0;
        ifc.addr   = '0;
        ifc.nbeats = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // single short burst
        start_xfer(32'h0, 10, 1'b0, -1);
        wait_done(200);

        // split on MAX_BURST
        start_xfer(32'h0, 600, 1'b1, -1);
        wait_done(400);

        // near a 4 KiB page end
        start_xfer(32'h0000_0FF0, 8, 1'b0, -1);
        wait_done(200);

        // error reported with the first burst's completion abandons the rest
        start_xfer(32'h0000_2000, 600, 1'b1, 0);
        wait_done(400);
        repeat (3) @(negedge clk);
        check("error_still_set", ifc.error, 1);

        // empty transfer: done two cycles after start, no run
        start_xfer(32'h0000_0100, 0, 1'b0, -1);
        @(negedge clk);
        check("empty_done_2cyc", ifc.done, 1);
        wait_done(4);

        // start pulsed while busy must not disturb the transfer
        start_xfer(32'h0001_0000, 600, 1'b1, -1);
        repeat (5) @(negedge clk);
        ifc.start  = 1'b1;
        ifc.addr   = 32'h0000_5000;
        ifc.nbeats = 16'd5;
        ifc.dir    = 1'b0;
        @(negedge clk);
        ifc.start  = 1'b0;
        wait_done(400);

        // asynchronous reset while a burst is in WAIT
        start_xfer(32'h0000_3000, 600, 1'b1, -1);
        cyc = 0;
        while (!ifc.run && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("run_before_reset", ifc.run, 1);
        @(negedge clk);
        check("in_wait", dbg_state, ST_WAIT);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_addr_q.delete();
        exp_len_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", dbg_state, ST_IDLE);
        start_xfer(32'h0000_0FF0, 8, 1'b0, -1);
        wait_done(200);

        // random descriptors
        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 2) == 0) ra[11:0] = 12'(12'hF00 + 4 * $urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) ra[31:12] = 20'hFFFFF;
            rn = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 700));
            re = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            start_xfer(ra, rn, 1'($urandom_range(0, 1)), re);
            wait_done(2000);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
